// File: rtl/imm_pkg.sv
// imm_pkg: format op encodings, opcodes and funct3 constants for immediate generation
package imm_pkg;
  typedef enum logic [2:0] {
    SEXT_I    = 3'd0,
    SEXT_S    = 3'd1,
    SEXT_B    = 3'd2,
    SEXT_J    = 3'd3,
    SEXT_U    = 3'd4,
    SEXT_Z    = 3'd5,
    SEXT_RSV  = 3'd6,
    SEXT_AUTO = 3'd7
  } sext_op_e;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRX    = 3'b101;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: resolves the immediate format and produces the XLEN-wide extended immediate
module imm_decode import imm_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [31:0]     din,
  output logic [XLEN-1:0] ext,
  output logic [2:0]      fmt,
  output logic            illegal
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic csr_imm;
  logic shamt;
  logic [XLEN-1:0] shamt_ext;
  assign opcode = din[6:0];
  assign funct3 = din[14:12];
  assign csr_imm = funct3 inside {F3_CSRRWI, F3_CSRRSI, F3_CSRRCI};
  assign shamt = fmt == SEXT_I && (opcode == OPC_OP_IMM || opcode == OPC_OP_IMM32)
                 && (funct3 == F3_SLL || funct3 == F3_SRX);
  assign shamt_ext = (XLEN == 64 && opcode == OPC_OP_IMM) ? XLEN'(din[25:20]) : XLEN'(din[24:20]);
  // format resolution: explicit op passes through, AUTO maps the opcode, unknowns flag illegal as I
  always_comb begin
    fmt = SEXT_I;
    illegal = 1'b0;
    if (op == SEXT_AUTO) begin
      case (opcode)
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = SEXT_I;
        OPC_OP_IMM32:                   illegal = XLEN != 64;
        OPC_STORE:                      fmt = SEXT_S;
        OPC_BRANCH:                     fmt = SEXT_B;
        OPC_JAL:                        fmt = SEXT_J;
        OPC_LUI, OPC_AUIPC:             fmt = SEXT_U;
        OPC_SYSTEM: begin
          fmt = csr_imm ? SEXT_Z : SEXT_I;
          illegal = !csr_imm;
        end
        default:                        illegal = 1'b1;
      endcase
    end else if (op == SEXT_RSV) illegal = 1'b1;
    else fmt = op;
  end
  // immediate assembly per resolved format; illegal words yield zero
  always_comb begin
    ext = '0;
    if (!illegal) begin
      case (fmt)
        SEXT_I:  ext = shamt ? shamt_ext : XLEN'($signed(din[31:20]));
        SEXT_S:  ext = XLEN'($signed({din[31:25], din[11:7]}));
        SEXT_B:  ext = XLEN'($signed({din[31], din[7], din[30:25], din[11:8], 1'b0}));
        SEXT_J:  ext = XLEN'($signed({din[31], din[19:12], din[20], din[30:21], 1'b0}));
        SEXT_U:  ext = XLEN'($signed({din[31:12], 12'b0}));
        SEXT_Z:  ext = XLEN'(din[19:15]);
        default: ext = '0;
      endcase
    end
  end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with a two-entry valid/ready skid pipeline
module imm_gen_stage import imm_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       sext_op_i,
  input  logic [31:0]      din,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  ext_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int W = TAG_W + 4 + XLEN;
  logic [XLEN-1:0] dec_ext;
  logic [2:0] dec_fmt;
  logic dec_ill;
  logic [W-1:0] res, out_q, skid_q;
  logic out_v, skid_v, in_fire, out_fire;
  imm_decode #(.XLEN(XLEN)) u_dec (
    .op(sext_op_i),
    .din(din),
    .ext(dec_ext),
    .fmt(dec_fmt),
    .illegal(dec_ill)
  );
  assign res = {tag_i, dec_ill, dec_fmt, dec_ext};
  assign in_ready_o = !skid_v && !rst_i;
  assign in_fire = in_valid_i && in_ready_o;
  assign out_fire = out_v && out_ready_i;
  assign out_valid_o = out_v;
  assign {tag_o, illegal_o, fmt_o, ext_o} = out_q;
  // output register refills from skid first, then from the input; a stalled output diverts input to skid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_v <= 1'b0;
      skid_v <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      out_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (out_fire || !out_v) begin
      out_v <= skid_v || in_fire;
      skid_v <= 1'b0;
      if (skid_v) out_q <= skid_q;
      else if (in_fire) out_q <= res;
    end else if (in_fire) begin
      skid_v <= 1'b1;
      skid_q <= res;
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed and random checks of imm_gen_stage at XLEN 32 and 64 against a reference model
module tb_imm_gen_stage;
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] d;
    logic [31:0] tag;
  } ent_t;
  typedef struct packed {
    logic        ill;
    logic [2:0]  fmt;
    logic [63:0] ext;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] sext_op = 3'd0;
  logic [31:0] din = 32'd0, tag_in = 32'd0;
  logic ir32, ov32, ill32, ir64, ov64, ill64;
  logic [31:0] ext32, tag32, tag64;
  logic [63:0] ext64;
  logic [2:0] fmt32, fmt64;
  logic ov[2], ir[2], ill[2];
  logic [63:0] ext[2];
  logic [2:0] fmt[2];
  logic [31:0] tagv[2];
  ent_t q[2][$];
  int passed = 0, total = 0;
  logic [6:0] opcs [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h7F, 7'h33};
  always #5 clk = ~clk;
  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir32),
    .sext_op_i(sext_op), .din(din), .tag_i(tag_in), .out_valid_o(ov32), .out_ready_i(out_ready),
    .ext_o(ext32), .fmt_o(fmt32), .illegal_o(ill32), .tag_o(tag32)
  );
  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir64),
    .sext_op_i(sext_op), .din(din), .tag_i(tag_in), .out_valid_o(ov64), .out_ready_i(out_ready),
    .ext_o(ext64), .fmt_o(fmt64), .illegal_o(ill64), .tag_o(tag64)
  );
  assign ov[0] = ov32;
  assign ov[1] = ov64;
  assign ir[0] = ir32;
  assign ir[1] = ir64;
  assign ill[0] = ill32;
  assign ill[1] = ill64;
  assign ext[0] = {32'b0, ext32};
  assign ext[1] = ext64;
  assign fmt[0] = fmt32;
  assign fmt[1] = fmt64;
  assign tagv[0] = tag32;
  assign tagv[1] = tag64;

  function automatic exp_t model(input int xlen, input logic [2:0] op, input logic [31:0] d);
    exp_t r;
    logic [6:0] opc;
    logic [2:0] f3, f;
    logic il;
    longint v;
    opc = d[6:0];
    f3 = d[14:12];
    f = op;
    il = 1'b0;
    v = 0;
    if (op == 3'd6) il = 1'b1;
    else if (op == 3'd7) begin
      if (opc == 7'h13 || opc == 7'h03 || opc == 7'h67 || (opc == 7'h1B && xlen == 64)) f = 3'd0;
      else if (opc == 7'h23) f = 3'd1;
      else if (opc == 7'h63) f = 3'd2;
      else if (opc == 7'h6F) f = 3'd3;
      else if (opc == 7'h37 || opc == 7'h17) f = 3'd4;
      else if (opc == 7'h73 && f3 >= 3'd5) f = 3'd5;
      else il = 1'b1;
    end
    if (!il) begin
      case (f)
        3'd0: begin
          v = longint'(d[31:20]);
          if (v >= 2048) v -= 4096;
          if ((opc == 7'h13 || opc == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5))
            v = (xlen == 64 && opc == 7'h13) ? longint'(d[25:20]) : longint'(d[24:20]);
        end
        3'd1: begin
          v = longint'({d[31:25], d[11:7]});
          if (v >= 2048) v -= 4096;
        end
        3'd2: begin
          v = longint'(d[31]) * 4096 + longint'(d[7]) * 2048 + longint'(d[30:25]) * 32 + longint'(d[11:8]) * 2;
          if (v >= 4096) v -= 8192;
        end
        3'd3: begin
          v = longint'(d[31]) * 1048576 + longint'(d[19:12]) * 4096 + longint'(d[20]) * 2048 + longint'(d[30:21]) * 2;
          if (v >= 1048576) v -= 2097152;
        end
        3'd4: begin
          v = longint'(d[31:12]) * 4096;
          if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
        end
        3'd5: v = longint'(d[19:15]);
        default: v = 0;
      endcase
    end
    r.ill = il;
    r.fmt = il ? 3'd0 : f;
    r.ext = il ? 64'd0 : (xlen == 32 ? {32'b0, v[31:0]} : v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] d, input logic ordy,
                      input logic fl, input logic r);
    ent_t e;
    exp_t x;
    in_valid = v;
    sext_op = op;
    din = d;
    tag_in = $urandom;
    out_ready = ordy;
    flush = fl;
    rst = r;
    e.op = op;
    e.d = d;
    e.tag = tag_in;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        chk("rst_in_ready", ir[k], 0);
        q[k].delete();
      end else begin
        chk("out_valid", ov[k], q[k].size() != 0);
        chk("in_ready", ir[k], q[k].size() < 2);
        if (ov[k] && ordy && q[k].size() != 0) begin
          x = model(k ? 64 : 32, q[k][0].op, q[k][0].d);
          chk("ext", ext[k], x.ext);
          chk("fmt", fmt[k], x.fmt);
          chk("illegal", ill[k], x.ill);
          chk("tag", tagv[k], q[k][0].tag);
          void'(q[k].pop_front());
        end
        if (fl) q[k].delete();
        else if (v && ir[k]) q[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input logic [2:0] op, input logic [31:0] d, input logic [63:0] e32, input logic [63:0] e64,
                     input logic [2:0] f, input logic il);
    step(1'b1, op, d, 1'b1, 1'b0, 1'b0);
    chk("dir_valid32", ov[0], 1);
    chk("dir_valid64", ov[1], 1);
    chk("dir_ext32", ext[0], e32);
    chk("dir_ext64", ext[1], e64);
    chk("dir_fmt", fmt[1], f);
    chk("dir_illegal", ill[1], il);
  endtask

  initial begin
    logic [31:0] d;
    logic [2:0] op;
    step(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", ov[k], 0);
      chk("reset_ready", ir[k], 1);
      chk("reset_ext", ext[k], 0);
      chk("reset_fmt", fmt[k], 0);
      chk("reset_illegal", ill[k], 0);
      chk("reset_tag", tagv[k], 0);
    end
    dir(3'd7, 32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0);
    dir(3'd7, 32'h123450B7, 64'h1234_5000, 64'h1234_5000, 3'd4, 1'b0);
    dir(3'd7, 32'h01F09093, 64'h1F, 64'h1F, 3'd0, 1'b0);
    dir(3'd7, 32'h4030D093, 64'h3, 64'h3, 3'd0, 1'b0);
    dir(3'd7, 32'h03F09093, 64'h1F, 64'h3F, 3'd0, 1'b0);
    dir(3'd7, 32'hFE000EE3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    dir(3'd7, 32'hFF9FF06F, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);
    dir(3'd7, 32'h800000B7, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    dir(3'd7, 32'h3057D073, 64'hF, 64'hF, 3'd5, 1'b0);
    dir(3'd7, 32'h0000007F, 64'h0, 64'h0, 3'd0, 1'b1);
    dir(3'd6, 32'hFFF00093, 64'h0, 64'h0, 3'd0, 1'b1);
    dir(3'd1, 32'hFE000FA3, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00100093, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00200093, 1'b0, 1'b0, 1'b0);
    chk("bp_ready32", ir[0], 0);
    chk("bp_ready64", ir[1], 0);
    step(1'b1, 3'd7, 32'h00300093, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00300093, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00300093, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00400093, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00500093, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00600093, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", ov[1], 0);
    chk("flush_ready", ir[1], 1);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00700093, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00800093, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h00900093, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_mid_valid", ov[1], 0);
    chk("rst_mid_ext", ext[1], 0);
    chk("rst_mid_ready", ir[1], 1);
    dir(3'd7, 32'h123450B7, 64'h1234_5000, 64'h1234_5000, 3'd4, 1'b0);
    for (int i = 0; i < 800; i++) begin
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[6:0] = opcs[$urandom_range(0, 11)];
      op = $urandom_range(0, 1) ? 3'd7 : 3'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, op, d, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
